// File: rtl/ice_cmd_router_if.sv
// Bundle of decoder, channel and UART signals around the ICE command router.
// The master modport is the router's view; slave is the surrounding fabric.
interface ice_cmd_router_if #(
    parameter int unsigned NUM_CH = 2
) ();
    logic                  rx_valid;
    logic                  rx_is_hex;
    logic [3:0]            rx_hex;
    logic                  rx_is_cmd;
    logic [3:0]            rx_cmd;
    logic                  rx_is_eol;
    logic [7:0]            ch_tx_byte;
    logic [NUM_CH-1:0]     ch_tx_latch;
    logic [NUM_CH-1:0]     ch_tx_req;
    logic                  ch_tx_mode;
    logic [NUM_CH-1:0]     ch_busy;
    logic [NUM_CH-1:0]     ch_resp_req;
    logic [NUM_CH-1:0]     ch_resp_valid;
    logic [8*NUM_CH-1:0]   ch_resp_data;
    logic [NUM_CH-1:0]     ch_resp_pop;
    logic [7:0]            uart_tx_data;
    logic                  uart_tx_latch;
    logic                  uart_tx_empty;
    logic                  err;

    modport master (
        input  rx_valid, rx_is_hex, rx_hex, rx_is_cmd, rx_cmd, rx_is_eol,
        input  ch_busy, ch_resp_req, ch_resp_valid, ch_resp_data, uart_tx_empty,
        output ch_tx_byte, ch_tx_latch, ch_tx_req, ch_tx_mode, ch_resp_pop,
        output uart_tx_data, uart_tx_latch, err
    );

    modport slave (
        output rx_valid, rx_is_hex, rx_hex, rx_is_cmd, rx_cmd, rx_is_eol,
        output ch_busy, ch_resp_req, ch_resp_valid, ch_resp_data, uart_tx_empty,
        input  ch_tx_byte, ch_tx_latch, ch_tx_req, ch_tx_mode, ch_resp_pop,
        input  uart_tx_data, uart_tx_latch, err
    );
endinterface

// File: rtl/ice_cmd_router.sv
// ICE command router: decoded UART events become per-channel byte frames (TX),
// channel responses become round-robin framed hex ASCII lines (RX).
module ice_cmd_router #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned MAX_BYTES = 16,
    parameter logic [7:0]  HDR_BASE  = 8'h61
) (
    input  logic             i_clk,
    input  logic             i_reset,
    ice_cmd_router_if.master io_bus
);
    localparam int unsigned BCW  = $clog2(MAX_BYTES + 1);
    localparam int unsigned PTRW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {TxIdle, TxCollect, TxFinal, TxDiscard} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxHdr, RxHi, RxLo, RxEol} rx_state_e;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    tx_state_e         r_tx_state, w_tx_state_nxt;
    logic [2:0]        r_ch, w_ch_nxt;
    logic              r_mode, w_mode_nxt;
    logic [3:0]        r_nib, w_nib_nxt;
    logic              r_odd, w_odd_nxt;
    logic [BCW-1:0]    r_bcnt, w_bcnt_nxt;
    logic [7:0]        r_tx_byte, w_tx_byte_nxt;
    logic [NUM_CH-1:0] r_tx_latch, w_tx_latch_nxt;
    logic [NUM_CH-1:0] r_tx_req, w_tx_req_nxt;
    logic              r_err, w_err_nxt;

    logic [2:0]        w_cmd_ch;
    logic              w_cmd_busy;
    logic              w_cmd_ok;
    logic              w_full;
    logic [NUM_CH-1:0] w_ch_oh;

    assign w_cmd_ch = io_bus.rx_cmd[3:1];
    assign w_ch_oh  = NUM_CH'(1) << r_ch;
    assign w_full   = (r_bcnt == BCW'(MAX_BYTES));

    always_comb begin
        w_cmd_busy = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (3'(i) == w_cmd_ch) w_cmd_busy = io_bus.ch_busy[i];
        end
        w_cmd_ok = ({29'd0, w_cmd_ch} < NUM_CH) && !w_cmd_busy;
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_ch_nxt       = r_ch;
        w_mode_nxt     = r_mode;
        w_nib_nxt      = r_nib;
        w_odd_nxt      = r_odd;
        w_bcnt_nxt     = r_bcnt;
        w_tx_byte_nxt  = r_tx_byte;
        w_tx_latch_nxt = '0;
        w_tx_req_nxt   = '0;
        w_err_nxt      = 1'b0;
        if (io_bus.rx_valid && io_bus.rx_is_cmd) begin
            // A command always restarts; a frame that already latched bytes is dropped loudly.
            w_err_nxt = (r_tx_state == TxFinal) || !w_cmd_ok ||
                        ((r_tx_state == TxCollect) && (r_bcnt != '0));
            w_ch_nxt       = w_cmd_ch;
            w_mode_nxt     = io_bus.rx_cmd[0];
            w_odd_nxt      = 1'b0;
            w_bcnt_nxt     = '0;
            w_tx_state_nxt = w_cmd_ok ? TxCollect : TxDiscard;
        end else begin
            unique case (r_tx_state)
                TxCollect: begin
                    if (io_bus.rx_valid && io_bus.rx_is_hex) begin
                        if (!r_odd) begin
                            w_nib_nxt = io_bus.rx_hex;
                            w_odd_nxt = 1'b1;
                        end else if (w_full) begin
                            w_odd_nxt      = 1'b0;
                            w_err_nxt      = 1'b1;
                            w_tx_state_nxt = TxDiscard;
                        end else begin
                            w_odd_nxt      = 1'b0;
                            w_tx_byte_nxt  = {r_nib, io_bus.rx_hex};
                            w_tx_latch_nxt = w_ch_oh;
                            w_bcnt_nxt     = r_bcnt + BCW'(1);
                        end
                    end else if (io_bus.rx_valid && io_bus.rx_is_eol) begin
                        w_odd_nxt      = 1'b0;
                        w_tx_state_nxt = TxIdle;
                        if (r_odd && w_full) begin
                            w_err_nxt = 1'b1;
                        end else if (r_odd) begin
                            // Pad the dangling nibble, then request one cycle later.
                            w_tx_byte_nxt  = {r_nib, 4'h0};
                            w_tx_latch_nxt = w_ch_oh;
                            w_bcnt_nxt     = r_bcnt + BCW'(1);
                            w_tx_state_nxt = TxFinal;
                        end else if (r_bcnt != '0) begin
                            w_tx_req_nxt = w_ch_oh;
                        end
                    end
                end
                TxFinal: begin
                    w_tx_req_nxt   = w_ch_oh;
                    w_tx_state_nxt = TxIdle;
                end
                TxDiscard: begin
                    if (io_bus.rx_valid && io_bus.rx_is_eol) w_tx_state_nxt = TxIdle;
                end
                default: w_tx_state_nxt = TxIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_state <= TxIdle;
            r_ch       <= '0;
            r_mode     <= 1'b0;
            r_nib      <= '0;
            r_odd      <= 1'b0;
            r_bcnt     <= '0;
            r_tx_byte  <= '0;
            r_tx_latch <= '0;
            r_tx_req   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_ch       <= w_ch_nxt;
            r_mode     <= w_mode_nxt;
            r_nib      <= w_nib_nxt;
            r_odd      <= w_odd_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_tx_byte  <= w_tx_byte_nxt;
            r_tx_latch <= w_tx_latch_nxt;
            r_tx_req   <= w_tx_req_nxt;
            r_err      <= w_err_nxt;
        end
    end

    rx_state_e         r_rx_state, w_rx_state_nxt;
    logic [PTRW-1:0]   r_k, w_k_nxt;
    logic [PTRW-1:0]   r_ptr, w_ptr_nxt;
    logic [PTRW-1:0]   w_pick, w_idx;
    logic              w_found;
    logic [7:0]        r_uart_data, w_uart_data_nxt;
    logic              r_uart_latch, w_uart_latch_nxt;
    logic [NUM_CH-1:0] r_pop, w_pop_nxt;
    logic [7:0]        w_resp_data;
    logic              w_resp_valid;
    logic              w_can_send;

    // Round-robin search starting at the pointer, plus the selected channel's response mux.
    always_comb begin
        w_found      = 1'b0;
        w_pick       = '0;
        w_idx        = '0;
        w_resp_valid = 1'b0;
        w_resp_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = PTRW'((32'(r_ptr) + 32'(i)) % NUM_CH);
            if (!w_found && io_bus.ch_resp_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
            if (PTRW'(i) == r_k) begin
                w_resp_valid = io_bus.ch_resp_valid[i];
                w_resp_data  = io_bus.ch_resp_data[8*i +: 8];
            end
        end
    end

    assign w_can_send = io_bus.uart_tx_empty && !r_uart_latch;

    always_comb begin
        w_rx_state_nxt   = r_rx_state;
        w_k_nxt          = r_k;
        w_ptr_nxt        = r_ptr;
        w_uart_data_nxt  = r_uart_data;
        w_uart_latch_nxt = 1'b0;
        w_pop_nxt        = '0;
        unique case (r_rx_state)
            RxIdle: begin
                if (w_found) begin
                    w_k_nxt        = w_pick;
                    w_rx_state_nxt = RxHdr;
                end
            end
            RxHdr: begin
                if (w_can_send) begin
                    w_uart_latch_nxt = 1'b1;
                    w_uart_data_nxt  = HDR_BASE + 8'(r_k);
                    w_rx_state_nxt   = RxHi;
                end
            end
            RxHi: begin
                if (w_can_send && !w_resp_valid) begin
                    w_rx_state_nxt = RxEol;
                end else if (w_can_send) begin
                    w_uart_latch_nxt = 1'b1;
                    w_uart_data_nxt  = hex_ascii(w_resp_data[7:4]);
                    w_rx_state_nxt   = RxLo;
                end
            end
            RxLo: begin
                if (w_can_send) begin
                    w_uart_latch_nxt = 1'b1;
                    w_uart_data_nxt  = hex_ascii(w_resp_data[3:0]);
                    w_pop_nxt        = NUM_CH'(1) << r_k;
                    w_rx_state_nxt   = RxHi;
                end
            end
            RxEol: begin
                if (w_can_send) begin
                    w_uart_latch_nxt = 1'b1;
                    w_uart_data_nxt  = 8'h0a;
                    w_ptr_nxt        = (32'(r_k) == NUM_CH - 1) ? '0 : r_k + PTRW'(1);
                    w_rx_state_nxt   = RxIdle;
                end
            end
            default: w_rx_state_nxt = RxIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rx_state   <= RxIdle;
            r_k          <= '0;
            r_ptr        <= '0;
            r_uart_data  <= '0;
            r_uart_latch <= 1'b0;
            r_pop        <= '0;
        end else begin
            r_rx_state   <= w_rx_state_nxt;
            r_k          <= w_k_nxt;
            r_ptr        <= w_ptr_nxt;
            r_uart_data  <= w_uart_data_nxt;
            r_uart_latch <= w_uart_latch_nxt;
            r_pop        <= w_pop_nxt;
        end
    end

    assign io_bus.ch_tx_byte    = r_tx_byte;
    assign io_bus.ch_tx_latch   = r_tx_latch;
    assign io_bus.ch_tx_req     = r_tx_req;
    assign io_bus.ch_tx_mode    = r_mode;
    assign io_bus.err           = r_err;
    assign io_bus.uart_tx_data  = r_uart_data;
    assign io_bus.uart_tx_latch = r_uart_latch;
    assign io_bus.ch_resp_pop   = r_pop;

endmodule

// File: tb/tb_ice_cmd_router.sv
// Directed bench for ice_cmd_router: a negedge recorder logs DUT strobes, and each
// scenario task compares the log against hand-derived expectations.
module tb_ice_cmd_router;
    localparam int unsigned NUM_CH = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ice_cmd_router_if #(.NUM_CH(NUM_CH)) bus ();

    ice_cmd_router #(
        .NUM_CH   (NUM_CH),
        .MAX_BYTES(16),
        .HDR_BASE (8'h61)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .io_bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Recorder state
    int         cyc = 0;
    int         eol_cyc = -1;
    int         lat_q[$];
    int         lat_cyc[$];
    int         req_q[$];
    int         req_cyc[$];
    logic [7:0] uart_q[$];
    int         err_cnt = 0;
    int         b2b_cnt = 0;
    int         pop_cnt[NUM_CH];
    logic       prev_ulatch = 1'b0;

    // Channel response model
    logic [NUM_CH-1:0] req_force = '0;
    logic [NUM_CH-1:0] ch_reload = '0;
    logic [7:0]        ch_mem[NUM_CH][4];
    int                ch_len[NUM_CH];
    int                ch_idx[NUM_CH];

    always_comb begin
        bus.ch_resp_valid = '0;
        bus.ch_resp_req   = '0;
        bus.ch_resp_data  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            bus.ch_resp_valid[k]      = ch_idx[k] < ch_len[k];
            bus.ch_resp_req[k]        = req_force[k] || (ch_idx[k] < ch_len[k]);
            bus.ch_resp_data[8*k +: 8] = ch_mem[k][ch_idx[k][1:0]];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_reload[k]) ch_idx[k] <= 0;
            else if (bus.ch_resp_pop[k]) ch_idx[k] <= ch_idx[k] + 1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_ulatch = 1'b0;
        end else begin
            cyc = cyc + 1;
            if (bus.rx_valid && bus.rx_is_eol) eol_cyc = cyc;
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.ch_tx_latch[k]) begin
                    lat_q.push_back((k << 12) | (int'(bus.ch_tx_mode) << 8) | int'(bus.ch_tx_byte));
                    lat_cyc.push_back(cyc);
                end
                if (bus.ch_tx_req[k]) begin
                    req_q.push_back((k << 8) | int'(bus.ch_tx_mode));
                    req_cyc.push_back(cyc);
                end
                if (bus.ch_resp_pop[k]) pop_cnt[k] = pop_cnt[k] + 1;
            end
            if (bus.err) err_cnt = err_cnt + 1;
            if (bus.uart_tx_latch) begin
                uart_q.push_back(bus.uart_tx_data);
                if (prev_ulatch) b2b_cnt = b2b_cnt + 1;
            end
            prev_ulatch = bus.uart_tx_latch;
        end
    end

    function automatic int qi(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_logs();
        lat_q.delete();
        lat_cyc.delete();
        req_q.delete();
        req_cyc.delete();
        uart_q.delete();
        err_cnt = 0;
        b2b_cnt = 0;
        for (int k = 0; k < NUM_CH; k++) pop_cnt[k] = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic c, input logic h, input logic e, input logic [3:0] v);
        bus.rx_valid  = 1'b1;
        bus.rx_is_cmd = c;
        bus.rx_is_hex = h;
        bus.rx_is_eol = e;
        bus.rx_cmd    = v;
        bus.rx_hex    = v;
        @(posedge clk);
        #1;
        bus.rx_valid  = 1'b0;
        bus.rx_is_cmd = 1'b0;
        bus.rx_is_hex = 1'b0;
        bus.rx_is_eol = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [3:0] v); ev(1'b1, 1'b0, 1'b0, v); endtask
    task automatic hex(input logic [3:0] v); ev(1'b0, 1'b1, 1'b0, v); endtask
    task automatic eol();                    ev(1'b0, 1'b0, 1'b1, 4'h0); endtask

    task automatic load_ch(input int k, input logic [7:0] b0, input logic [7:0] b1, input int n);
        ch_reload[k] = 1'b1;
        @(posedge clk);
        #1;
        ch_reload[k] = 1'b0;
        ch_mem[k][0] = b0;
        ch_mem[k][1] = b1;
        ch_len[k]    = n;
    endtask

    task automatic wait_uart(input int n, input int budget);
        for (int i = 0; i < budget && uart_q.size() < n; i++) @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] outs();
        return {bus.ch_tx_byte, bus.ch_tx_latch, bus.ch_tx_req, bus.ch_tx_mode,
                bus.ch_resp_pop, bus.uart_tx_data, bus.uart_tx_latch, bus.err};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (outs() !== 25'd0) begin
            n_bad++; $display("FAIL reset.outputs got %h want 0", outs());
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
        idle(4);
        n_vec++;
        if (outs() !== 25'd0) begin
            n_bad++; $display("FAIL reset.idle_outputs got %h want 0", outs());
        end
        n_vec++;
        if (uart_q.size() !== 0) begin
            n_bad++; $display("FAIL reset.uart_quiet got %0d chars want 0", uart_q.size());
        end
    endtask

    task automatic test_two_bytes();
        clear_logs();
        cmd(4'h0); hex(4'hA); hex(4'h5); hex(4'h3); hex(4'hC); eol();
        idle(4);
        n_vec++;
        if (lat_q.size() !== 2) begin
            n_bad++; $display("FAIL two.lat_count got %0d want 2", lat_q.size());
        end
        n_vec++;
        if (qi(lat_q, 0) !== 'h0A5) begin
            n_bad++; $display("FAIL two.lat0 got %h want 0a5", qi(lat_q, 0));
        end
        n_vec++;
        if (qi(lat_q, 1) !== 'h03C) begin
            n_bad++; $display("FAIL two.lat1 got %h want 03c", qi(lat_q, 1));
        end
        n_vec++;
        if (req_q.size() !== 1 || qi(req_q, 0) !== 'h000) begin
            n_bad++; $display("FAIL two.req got n=%0d %h want n=1 000", req_q.size(), qi(req_q, 0));
        end
        n_vec++;
        if (qi(req_cyc, 0) !== eol_cyc + 1) begin
            n_bad++; $display("FAIL two.req_time got %0d want %0d", qi(req_cyc, 0), eol_cyc + 1);
        end
        n_vec++;
        if (err_cnt !== 0) begin
            n_bad++; $display("FAIL two.err got %0d want 0", err_cnt);
        end
    endtask

    task automatic test_odd_nibble();
        clear_logs();
        cmd(4'h3); hex(4'h7); eol();
        idle(4);
        n_vec++;
        if (lat_q.size() !== 1 || qi(lat_q, 0) !== 'h1170) begin
            n_bad++; $display("FAIL odd.lat got n=%0d %h want n=1 1170", lat_q.size(), qi(lat_q, 0));
        end
        n_vec++;
        if (qi(lat_cyc, 0) !== eol_cyc + 1) begin
            n_bad++; $display("FAIL odd.lat_time got %0d want %0d", qi(lat_cyc, 0), eol_cyc + 1);
        end
        n_vec++;
        if (req_q.size() !== 1 || qi(req_q, 0) !== 'h101) begin
            n_bad++; $display("FAIL odd.req got n=%0d %h want n=1 101", req_q.size(), qi(req_q, 0));
        end
        n_vec++;
        if (qi(req_cyc, 0) !== eol_cyc + 2) begin
            n_bad++; $display("FAIL odd.req_time got %0d want %0d", qi(req_cyc, 0), eol_cyc + 2);
        end
    endtask

    task automatic test_reject();
        clear_logs();
        cmd(4'h9); hex(4'h1); hex(4'h2); eol();
        idle(3);
        n_vec++;
        if (err_cnt !== 1 || lat_q.size() !== 0 || req_q.size() !== 0) begin
            n_bad++; $display("FAIL bad_ch got err=%0d lat=%0d req=%0d want 1 0 0",
                              err_cnt, lat_q.size(), req_q.size());
        end
        clear_logs();
        bus.ch_busy = 2'b01;
        cmd(4'h0); hex(4'h1); hex(4'h2); eol();
        idle(3);
        bus.ch_busy = 2'b00;
        n_vec++;
        if (err_cnt !== 1 || lat_q.size() !== 0 || req_q.size() !== 0) begin
            n_bad++; $display("FAIL busy got err=%0d lat=%0d req=%0d want 1 0 0",
                              err_cnt, lat_q.size(), req_q.size());
        end
        clear_logs();
        cmd(4'h0); eol();
        idle(3);
        n_vec++;
        if (err_cnt !== 0 || lat_q.size() !== 0 || req_q.size() !== 0) begin
            n_bad++; $display("FAIL empty got err=%0d lat=%0d req=%0d want 0 0 0",
                              err_cnt, lat_q.size(), req_q.size());
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        clear_logs();
        cmd(4'h0);
        for (int i = 0; i < 17; i++) begin
            b = 8'(i * 7 + 1);
            hex(b[7:4]);
            hex(b[3:0]);
        end
        eol();
        idle(3);
        n_vec++;
        if (lat_q.size() !== 16) begin
            n_bad++; $display("FAIL ovf.lat_count got %0d want 16", lat_q.size());
        end
        n_vec++;
        if (qi(lat_q, 15) !== 'h06A) begin
            n_bad++; $display("FAIL ovf.lat15 got %h want 06a", qi(lat_q, 15));
        end
        n_vec++;
        if (err_cnt !== 1 || req_q.size() !== 0) begin
            n_bad++; $display("FAIL ovf.err_req got err=%0d req=%0d want 1 0", err_cnt, req_q.size());
        end
    endtask

    task automatic test_abort();
        clear_logs();
        cmd(4'h0); hex(4'h1); hex(4'h2);
        cmd(4'h2); hex(4'h4); hex(4'h5); eol();
        idle(4);
        n_vec++;
        if (lat_q.size() !== 2 || qi(lat_q, 0) !== 'h012 || qi(lat_q, 1) !== 'h1045) begin
            n_bad++; $display("FAIL abort.lat got n=%0d %h %h want n=2 012 1045",
                              lat_q.size(), qi(lat_q, 0), qi(lat_q, 1));
        end
        n_vec++;
        if (req_q.size() !== 1 || qi(req_q, 0) !== 'h100) begin
            n_bad++; $display("FAIL abort.req got n=%0d %h want n=1 100", req_q.size(), qi(req_q, 0));
        end
        n_vec++;
        if (err_cnt !== 1) begin
            n_bad++; $display("FAIL abort.err got %0d want 1", err_cnt);
        end
    endtask

    task automatic test_uart_single();
        logic [7:0] exp_s[6];
        exp_s = '{8'h62, 8'h42, 8'h34, 8'h30, 8'h46, 8'h0a};
        clear_logs();
        bus.uart_tx_empty = 1'b0;
        load_ch(1, 8'hB4, 8'h0F, 2);
        idle(10);
        n_vec++;
        if (uart_q.size() !== 0) begin
            n_bad++; $display("FAIL uart.not_empty got %0d chars want 0", uart_q.size());
        end
        bus.uart_tx_empty = 1'b1;
        wait_uart(6, 200);
        idle(10);
        n_vec++;
        if (uart_q.size() !== 6) begin
            n_bad++; $display("FAIL uart.count got %0d want 6", uart_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (i >= uart_q.size() || uart_q[i] !== exp_s[i]) begin
                n_bad++; $display("FAIL uart.char%0d got %h want %h", i,
                                  (i < uart_q.size()) ? uart_q[i] : 8'hxx, exp_s[i]);
            end
        end
        n_vec++;
        if (pop_cnt[1] !== 2 || pop_cnt[0] !== 0) begin
            n_bad++; $display("FAIL uart.pops got ch0=%0d ch1=%0d want 0 2", pop_cnt[0], pop_cnt[1]);
        end
        n_vec++;
        if (b2b_cnt !== 0) begin
            n_bad++; $display("FAIL uart.back_to_back got %0d want 0", b2b_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_s[6];
        exp_s = '{8'h61, 8'h0a, 8'h62, 8'h0a, 8'h61, 8'h0a};
        clear_logs();
        req_force = 2'b11;
        wait_uart(6, 200);
        req_force = 2'b00;
        idle(20);
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (i >= uart_q.size() || uart_q[i] !== exp_s[i]) begin
                n_bad++; $display("FAIL rr.char%0d got %h want %h", i,
                                  (i < uart_q.size()) ? uart_q[i] : 8'hxx, exp_s[i]);
            end
        end
        n_vec++;
        if (b2b_cnt !== 0) begin
            n_bad++; $display("FAIL rr.back_to_back got %0d want 0", b2b_cnt);
        end
    endtask

    task automatic test_reset_mid();
        cmd(4'h0); hex(4'h1); hex(4'h2); hex(4'h3);
        req_force = 2'b01;
        idle(3);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (outs() !== 25'd0) begin
            n_bad++; $display("FAIL rst_mid.outputs got %h want 0", outs());
        end
        req_force = 2'b00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
        eol();
        idle(6);
        n_vec++;
        if (lat_q.size() !== 0 || req_q.size() !== 0 || err_cnt !== 0 || uart_q.size() !== 0) begin
            n_bad++; $display("FAIL rst_mid.after got lat=%0d req=%0d err=%0d uart=%0d want 0 0 0 0",
                              lat_q.size(), req_q.size(), err_cnt, uart_q.size());
        end
    endtask

    initial begin
        bus.rx_valid      = 1'b0;
        bus.rx_is_hex     = 1'b0;
        bus.rx_hex        = 4'h0;
        bus.rx_is_cmd     = 1'b0;
        bus.rx_cmd        = 4'h0;
        bus.rx_is_eol     = 1'b0;
        bus.ch_busy       = '0;
        bus.uart_tx_empty = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_len[k] = 0;
            ch_idx[k] = 0;
            pop_cnt[k] = 0;
            for (int j = 0; j < 4; j++) ch_mem[k][j] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_two_bytes();
        test_odd_nibble();
        test_reject();
        test_overflow();
        test_abort();
        test_uart_single();
        test_round_robin();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ice_cmd_router.md
Name: ice_cmd_router

Overview:
- Parametrised successor to the ICE top-level command controller.
- Sits between the UART/character-decoder pair and NUM_CH bus-interface channels (PINT, discrete I2C, future ports).
- TX path parses decoded command/hex/EOL events into per-channel byte streams with a request strobe.
- RX path round-robin arbitrates channel responses into framed, hex-encoded ASCII lines on the UART.

Parameters:
- NUM_CH, 2, number of downstream channels (1..8).
- MAX_BYTES, 16, maximum payload bytes per TX frame (1..255).
- HDR_BASE, 8'h61, ASCII header for channel 0; channel k uses HDR_BASE+k.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  decoder event strobe, one cycle per received character.
- rx_is_hex  in  1  event is a hex digit.
- rx_hex  in  4  decoded nibble.
- rx_is_cmd  in  1  event is a command character.
- rx_cmd  in  4  decoded command code.
- rx_is_eol  in  1  event is end-of-line.
- ch_tx_byte  out  8  payload byte, shared by all channels.
- ch_tx_latch  out  NUM_CH  one-hot strobe: ch_tx_byte valid for channel k.
- ch_tx_req  out  NUM_CH  one-hot strobe: frame complete, channel k transmits.
- ch_tx_mode  out  1  mode bit for the current frame (rx_cmd[0]); valid with latch/req.
- ch_busy  in  NUM_CH  channel cannot accept a new frame.
- ch_resp_req  in  NUM_CH  channel k has a response pending.
- ch_resp_valid  in  NUM_CH  channel k response byte available.
- ch_resp_data  in  8*NUM_CH  response byte of channel k at [8k+7:8k].
- ch_resp_pop  out  NUM_CH  one-hot: consume channel k response byte.
- uart_tx_data  out  8  character to UART.
- uart_tx_latch  out  1  one-cycle load strobe to UART.
- uart_tx_empty  in  1  UART transmitter ready.
- err  out  1  one-cycle pulse on any dropped frame.

Behaviour:
- Reset: all outputs 0; both FSMs in IDLE; nibble count, byte count, arbiter pointer and abort flag cleared. Reset mid-frame discards the frame with no req/latch/err pulse.
- Command decode: channel = rx_cmd[3:1], mode = rx_cmd[0].
- TX FSM states:
  - IDLE: rx_is_cmd with channel<NUM_CH and !ch_busy[channel] -> COLLECT (channel and mode captured). Channel>=NUM_CH or busy -> DISCARD, err pulse.
  - COLLECT: each rx_is_hex shifts the nibble in. On every second nibble, ch_tx_byte={first,second} and ch_tx_latch[ch] pulse in the cycle after the second nibble event. Byte count increments per latched byte.
  - Byte MAX_BYTES+1 attempted -> DISCARD, err pulse, no req.
  - rx_is_eol in COLLECT with an odd nibble count: latch final byte {nibble,4'h0}, then ch_tx_req[ch] the next cycle. Even count >=2: req 1 cycle after EOL. Zero bytes: no req, no err. Then -> IDLE.
  - DISCARD: ignore hex; rx_is_eol -> IDLE.
  - rx_is_cmd in any state aborts the current frame (no req, err pulse if bytes already latched) and is evaluated as a new IDLE command in the same cycle.
- RX FSM states:
  - IDLE: pick the lowest k at or after pointer with ch_resp_req[k] -> HDR. Pointer = k+1 mod NUM_CH on EOL exit.
  - HDR: send HDR_BASE+k.
  - HI: ch_resp_valid[k] low -> EOL. Else send ASCII hex of data[7:4].
  - LO: send data[3:0], pulse ch_resp_pop[k] with the send, -> HI.
  - EOL: send 8'h0a -> IDLE.
- Hex encoding: 0-9 -> 8'h30+n, A-F -> 8'h41+n-10 (uppercase).
- UART handshake: uart_tx_latch is registered, asserted only when uart_tx_empty=1 and latch was not asserted the previous cycle; uart_tx_data is held stable with the latch. Max one character per 2 cycles.
- TX and RX paths are fully independent; simultaneous activity is legal.

Test Plan:
- Cmd 0, hex "A5 3C", EOL -> latch[0] 8'hA5, latch[0] 8'h3C, req[0] with mode=0; err stays 0.
- Cmd 3, hex "7", EOL -> latch[1] 8'h70, then req[1] with mode=1.
- Cmd 9 with NUM_CH=2 -> err pulse; following hex and EOL produce no latch/req. Separately, 17 bytes with MAX_BYTES=16 -> 16 latches, err, no req.
- Cmd 0, "12", then cmd 2 mid-frame -> err, no req[0]; the new frame on ch1 completes normally.
- ch_resp_req[1] with bytes 8'hB4, 8'h0F, uart_tx_empty=1 -> UART sees 'b','B','4','0','F',0x0a; 2 pops; no back-to-back latches.
- ch_resp_req=2'b11 held -> alternating ch0/ch1 frames. Reset asserted mid-frame -> all outputs 0 next cycle.
